// File: rtl/selector_pkg.sv
// Shared definitions for the packed selector bus: width helpers, FSM states
// and the entry layout used by both the packer and the selector array.
package selector_pkg;

    function automatic int unsigned vw_of(input int unsigned size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

    function automatic int unsigned iw_of(input int unsigned k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

    function automatic int unsigned w_of(input int unsigned size, input int unsigned k);
        return iw_of(k) + vw_of(size);
    endfunction

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Entry layout {index, value}; callers truncate the result to W bits.
    function automatic logic [31:0] entry(input int unsigned idx, input int unsigned val,
                                          input int unsigned vw);
        return (idx << vw) | (val & ((32'd1 << vw) - 32'd1));
    endfunction

endpackage

// File: rtl/value_tracker.sv
// Remembers which values have appeared in the current word and flags any
// repeat. Out-of-range values (non power-of-two SIZE) are ignored.
module value_tracker
    import selector_pkg::*;
#(
    parameter  int unsigned SIZE = 16,
    localparam int unsigned VW   = vw_of(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [VW-1:0] value,
    input  logic          clear,
    output logic          dup
);

    localparam int unsigned NV = 1 << VW;

    // Padded to the full value space so indexing is always in range.
    logic [NV-1:0] seen;
    logic          in_range;
    logic          hit;

    generate
        if (NV == SIZE) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (32'(value) < SIZE);
        end
    endgenerate

    assign hit = in_range && seen[value];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen <= '0;
            dup  <= 1'b0;
        end else if (clear) begin
            seen <= '0;
            dup  <= 1'b0;
        end else if (set && in_range) begin
            if (hit) dup <= 1'b1;
            seen[value] <= 1'b1;
        end
    end

endmodule

// File: rtl/selector_packer.sv
// Collects K values one per handshake, tags each with its slot index and
// presents the packed word plus a duplicate flag on a valid/ready output.
module selector_packer
    import selector_pkg::*;
#(
    parameter  int unsigned SIZE = 16,
    parameter  int unsigned K    = 8,
    localparam int unsigned VW   = vw_of(SIZE),
    localparam int unsigned IW   = iw_of(K),
    localparam int unsigned W    = w_of(SIZE, K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           in_valid,
    input  logic [VW-1:0]  in_value,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*K-1:0] packed_word,
    output logic           dup,
    output logic [IW:0]    fill
);

    localparam logic [IW:0] LAST = (IW+1)'(K - 1);

    state_t              state_q, state_d;
    logic [IW:0]         fill_q;
    logic [K-1:0][W-1:0] slots;
    logic                accept;
    logic                drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && fill_q == LAST) state_d = FULL;
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        if (clear) state_d = COLLECT;
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
            slots  <= '0;
        end else if (clear || drain) begin
            fill_q <= '0;
            slots  <= '0;
        end else if (accept) begin
            slots[fill_q[IW-1:0]] <= W'(entry(32'(fill_q[IW-1:0]), 32'(in_value), VW));
            fill_q                <= fill_q + 1'b1;
        end
    end

    // clear outranks the accept inside the tracker, matching the slot file.
    value_tracker #(.SIZE(SIZE)) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .set   (accept),
        .value (in_value),
        .clear (clear || drain),
        .dup   (dup)
    );

    assign packed_word = slots;
    assign fill        = fill_q;

endmodule

// File: tb/tb_selector_packer.sv
// Self-checking bench for selector_packer (K=8, SIZE=16).
module tb_selector_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_value;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] packed_word;
    logic        dup;
    logic [3:0]  fill;

    always #5 clk = ~clk;

    selector_packer #(.SIZE(16), .K(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_value    (in_value),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .packed_word (packed_word),
        .dup         (dup),
        .fill        (fill)
    );

    typedef struct {
        logic [3:0] v [8];
        bit         gaps;
        logic       exp_dup;
    } vec_t;

    typedef struct packed {
        logic [55:0] word;
        logic        d;
    } exp_t;

    vec_t       tbl [5];
    exp_t       sb [$];
    logic [3:0] cur [8];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [55:0] model(input int n);
        logic [55:0] r;
        logic [2:0]  ix;
        r = '0;
        for (int j = 0; j < n; j++) begin
            ix = 3'(j);
            r[j*7 +: 7] = {ix, cur[j]};
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cur(input bit gaps, input logic exp_dup);
        exp_t e;
        e.word = model(8);
        e.d    = exp_dup;
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_value = 4'($urandom);
                    step();
                    chk("gap fill stall", 64'(fill), 64'(i));
                end
            end
            in_valid = 1'b1;
            in_value = cur[i];
            step();
            in_valid = 1'b0;
            if (i == 6) begin
                chk("out_valid before 8th", 64'(out_valid), 64'd0);
                chk("fill after 7", 64'(fill), 64'd7);
            end
        end
    endtask

    task automatic expect_full();
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("out_valid latency", 64'(n), 64'd0);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard underflow: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("packed word", 64'(packed_word), 64'(e.word));
            chk("dup flag", 64'(dup), 64'(e.d));
            chk("in_ready in FULL", 64'(in_ready), 64'd0);
            chk("fill in FULL", 64'(fill), 64'd8);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain out_valid", 64'(out_valid), 64'd0);
        chk("drain fill", 64'(fill), 64'd0);
        chk("drain dup", 64'(dup), 64'd0);
        chk("drain packed", 64'(packed_word), 64'd0);
        chk("drain in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        tbl[0].v = '{4'd3, 4'd7, 4'd0, 4'd15, 4'd9, 4'd1, 4'd12, 4'd5};
        tbl[0].gaps = 1'b0; tbl[0].exp_dup = 1'b0;
        tbl[1].v = '{4'd4, 4'd4, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
        tbl[1].gaps = 1'b0; tbl[1].exp_dup = 1'b1;
        tbl[2].v = '{4'd10, 4'd2, 4'd14, 4'd6, 4'd11, 4'd8, 4'd13, 4'd0};
        tbl[2].gaps = 1'b1; tbl[2].exp_dup = 1'b0;
        tbl[3].v = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        tbl[3].gaps = 1'b1; tbl[3].exp_dup = 1'b1;
        tbl[4].v = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
        tbl[4].gaps = 1'b0; tbl[4].exp_dup = 1'b1;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset packed", 64'(packed_word), 64'd0);
        chk("reset dup", 64'(dup), 64'd0);
        chk("reset fill", 64'(fill), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        for (int t = 0; t < 5; t++) begin
            cur = tbl[t].v;
            send_cur(tbl[t].gaps, tbl[t].exp_dup);
            if (t == 0) begin
                chk("entry0", 64'(packed_word[6:0]), 64'h03);
                chk("entry3", 64'(packed_word[27:21]), 64'h3F);
                chk("entry7", 64'(packed_word[55:49]), 64'h75);
            end
            if (t == 1) chk("entry1", 64'(packed_word[13:7]), 64'h14);
            expect_full();
            drain();
        end

        // Backpressure: word held, input pulses ignored.
        cur = '{4'd8, 4'd6, 4'd4, 4'd2, 4'd1, 4'd3, 4'd5, 4'd7};
        send_cur(1'b0, 1'b0);
        expect_full();
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            in_value = 4'($urandom);
            step();
            chk("bp packed stable", 64'(packed_word), 64'(model(8)));
            chk("bp fill", 64'(fill), 64'd8);
            chk("bp out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        drain();

        // clear beats a concurrent accept.
        cur = '{4'd4, 4'd9, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_value = cur[i];
            step();
        end
        in_valid = 1'b0;
        chk("partial fill", 64'(fill), 64'd5);
        chk("partial packed", 64'(packed_word), 64'(model(5)));
        clear = 1'b1; in_valid = 1'b1; in_value = 4'd9;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear fill", 64'(fill), 64'd0);
        chk("clear packed", 64'(packed_word), 64'd0);
        chk("clear dup", 64'(dup), 64'd0);
        chk("clear in_ready", 64'(in_ready), 64'd1);

        // seen must be empty after clear: 4 and 9 appear once each here.
        cur = '{4'd4, 4'd9, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
        send_cur(1'b0, 1'b0);
        expect_full();
        clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0; out_ready = 1'b0;
        chk("clear+drain out_valid", 64'(out_valid), 64'd0);
        chk("clear+drain fill", 64'(fill), 64'd0);
        chk("clear+drain packed", 64'(packed_word), 64'd0);
        chk("clear+drain in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-word.
        cur = '{4'd2, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_value = cur[i];
            step();
        end
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async rst fill", 64'(fill), 64'd0);
        chk("async rst packed", 64'(packed_word), 64'd0);
        chk("async rst dup", 64'(dup), 64'd0);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        cur = tbl[0].v;
        send_cur(1'b0, 1'b0);
        expect_full();
        drain();

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
